// File: rtl/dcm_reset_sequencer.sv
// DCM reset/lock sequencer on the free-running board clock: pulses the DCM reset,
// waits for a stable lock with bounded retries, and supervises the running DCM.
module dcm_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES = 3,
    parameter int unsigned LOCK_TIMEOUT     = 65535,
    parameter int unsigned STABLE_CYCLES    = 16,
    parameter int unsigned RETRY_LIMIT      = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dcm_locked_i,
    input  logic [1:0] dcm_status_i,
    output logic       dcm_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam logic [23:0] PULSE_LAST   = 24'(RST_PULSE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(RETRY_LIMIT);

    typedef enum logic [2:0] {
        S_DCM_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic [3:0]  retry_n;
    logic [7:0]  loss_n;
    logic        attempt_fail;

    logic        locked_p0, locked_p1;
    logic [1:0]  status_p0, status_p1;
    logic        locked_s, stop_s;

    // p0 -> p1: two-flop synchronizers for the asynchronous DCM signals
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_p0 <= 1'b0;
            locked_p1 <= 1'b0;
            status_p0 <= 2'b00;
            status_p1 <= 2'b00;
        end else begin
            locked_p0 <= dcm_locked_i;
            locked_p1 <= locked_p0;
            status_p0 <= dcm_status_i;
            status_p1 <= status_p0;
        end
    end

    assign locked_s = locked_p1;
    assign stop_s   = |status_p1;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt + 24'd1;
        retry_n      = retry_cnt_o;
        loss_n       = loss_cnt_o;
        attempt_fail = 1'b0;
        case (state)
            S_DCM_RST: begin
                if (cnt == PULSE_LAST) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) state_n = S_STABLE;
                else if (cnt == TIMEOUT_LAST) attempt_fail = 1'b1;
            end
            S_STABLE: begin
                if (!locked_s || stop_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_n = S_RUN;
                    retry_n = 4'd0;
                end
            end
            S_RUN: begin
                cnt_n = '0;
                if (!locked_s || stop_s) begin
                    state_n = S_DCM_RST;
                    if (loss_cnt_o != 8'hFF) loss_n = loss_cnt_o + 8'd1;
                end
            end
            S_FAIL: begin
                cnt_n = '0;
            end
            default: begin
                state_n = S_DCM_RST;
            end
        endcase
        // A failed attempt either retries with a fresh reset pulse or gives up
        if (attempt_fail) begin
            if (retry_cnt_o == RETRY_MAX) begin
                state_n = S_FAIL;
            end else begin
                retry_n = retry_cnt_o + 4'd1;
                state_n = S_DCM_RST;
            end
        end
        if (state_n != state) cnt_n = '0;
    end

    // Outputs are decoded from the next state so they switch on the transition edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_DCM_RST;
            cnt         <= '0;
            dcm_rst_o   <= 1'b1;
            sys_rst_o   <= 1'b1;
            ready_o     <= 1'b0;
            fail_o      <= 1'b0;
            retry_cnt_o <= 4'd0;
            loss_cnt_o  <= 8'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dcm_rst_o   <= (state_n == S_DCM_RST);
            sys_rst_o   <= (state_n != S_RUN);
            ready_o     <= (state_n == S_RUN);
            fail_o      <= (state_n == S_FAIL);
            retry_cnt_o <= retry_n;
            loss_cnt_o  <= loss_n;
        end
    end

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Bench for dcm_reset_sequencer: directed scenarios plus random lock/status traces,
// each checked against an attempt-level reference model of the sequencing rules.
module tb_dcm_reset_sequencer;

    localparam int P    = 3;
    localparam int TO   = 20;
    localparam int SC   = 4;
    localparam int RL   = 2;
    localparam int NMAX = 4096;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       dcm_locked_i = 1'b0;
    logic [1:0] dcm_status_i = 2'b00;
    logic       dcm_rst_o, sys_rst_o, ready_o, fail_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    // Per-step trace: inputs sampled at edge i and outputs seen just after it
    logic        lk_a [NMAX];
    logic [1:0]  st_a [NMAX];
    logic        rs_a [NMAX];
    logic [15:0] obs  [NMAX];
    logic [15:0] exp_v[NMAX];
    int n;
    int n_chk = 0;
    int n_pass = 0;

    dcm_reset_sequencer #(
        .RST_PULSE_CYCLES(P),
        .LOCK_TIMEOUT    (TO),
        .STABLE_CYCLES   (SC),
        .RETRY_LIMIT     (RL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dcm_locked_i(dcm_locked_i),
        .dcm_status_i(dcm_status_i),
        .dcm_rst_o   (dcm_rst_o),
        .sys_rst_o   (sys_rst_o),
        .ready_o     (ready_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step(input logic l, input logic [1:0] s, input logic r);
        dcm_locked_i = l;
        dcm_status_i = s;
        rst_i        = r;
        @(posedge clk);
        #1;
        if (n < NMAX) begin
            lk_a[n] = l;
            st_a[n] = s;
            rs_a[n] = r;
            obs[n]  = {dcm_rst_o, sys_rst_o, ready_o, fail_o, retry_cnt_o, loss_cnt_o};
            n++;
        end
    endtask

    // Reference model: a decision at edge e sees the inputs from edge e-2
    function automatic logic ls(int e);
        if (e < 2) return 1'b0;
        if (rs_a[e-1] || rs_a[e-2]) return 1'b0;
        return lk_a[e-2];
    endfunction

    function automatic logic sp(int e);
        if (e < 2) return 1'b0;
        if (rs_a[e-1] || rs_a[e-2]) return 1'b0;
        return |st_a[e-2];
    endfunction

    function automatic void put(int e, int stop, logic d, logic s, logic r, logic f,
                                int retry, int loss);
        if (e < stop) exp_v[e] = {d, s, r, f, 4'(retry), 8'(loss)};
    endfunction

    task automatic run_seg(input int r, input int stop);
        int  s, e, v, k, retry, loss;
        bit  failed;
        s = r; retry = 0; loss = 0;
        forever begin
            for (int j = 0; j < P; j++) put(s + j, stop, 1, 1, 0, 0, retry, loss);
            e = s + P;
            if (e >= stop) return;
            put(e, stop, 0, 1, 0, 0, retry, loss);
            failed = 0;
            k = 0;
            while (1) begin
                e = s + P + 1 + k;
                if (e >= stop) return;
                if (ls(e)) break;
                if (k == TO - 1) begin failed = 1; break; end
                put(e, stop, 0, 1, 0, 0, retry, loss);
                k++;
            end
            if (!failed) begin
                put(e, stop, 0, 1, 0, 0, retry, loss);
                v = e;
                k = 0;
                while (1) begin
                    e = v + 1 + k;
                    if (e >= stop) return;
                    if (!ls(e) || sp(e)) begin failed = 1; break; end
                    if (k == SC - 1) break;
                    put(e, stop, 0, 1, 0, 0, retry, loss);
                    k++;
                end
            end
            if (failed) begin
                if (retry == RL) begin
                    for (int x = e; x < stop; x++) put(x, stop, 0, 1, 0, 1, retry, loss);
                    return;
                end
                retry++;
                s = e;
            end else begin
                retry = 0;
                put(e, stop, 0, 0, 1, 0, retry, loss);
                while (1) begin
                    e++;
                    if (e >= stop) return;
                    if (!ls(e) || sp(e)) break;
                    put(e, stop, 0, 0, 1, 0, retry, loss);
                end
                if (loss < 255) loss++;
                s = e;
            end
        end
    endtask

    task automatic model();
        int stop;
        for (int i = 0; i < n; i++) begin
            if (rs_a[i]) begin
                stop = i + 1;
                while (stop < n && !rs_a[stop]) stop++;
                run_seg(i, stop);
            end
        end
    endtask

    task automatic test_reset();
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        n_chk++;
        if (obs[1] !== 16'hC000) $display("FAIL reset_values got %h expected %h", obs[1], 16'hC000);
        else n_pass++;
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL reset_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_normal_lock();
        int hi, rise;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        for (int i = 2; i < 9; i++) step(0, 2'b00, 0);
        for (int i = 9; i < 30; i++) step(1, 2'b00, 0);
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL normal_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
        hi = 0;
        for (int i = 1; i < n; i++) hi += int'(obs[i][15]);
        n_chk++;
        if (hi !== 3) $display("FAIL normal_pulse_len got %0d expected 3", hi);
        else n_pass++;
        rise = -1;
        for (int i = n - 1; i >= 0; i--) if (obs[i][13]) rise = i;
        n_chk++;
        if (rise !== 15) $display("FAIL normal_ready_edge got %0d expected 15", rise);
        else n_pass++;
        n_chk++;
        if (obs[n-1][14:8] !== 7'b0100000) $display("FAIL normal_final got %b expected 0100000", obs[n-1][14:8]);
        else n_pass++;
    endtask

    task automatic test_timeout_retry();
        int rise2;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        for (int i = 2; i < 29; i++) step(0, 2'b00, 0);
        for (int i = 29; i < 50; i++) step(1, 2'b00, 0);
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL retry_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
        rise2 = -1;
        for (int i = n - 1; i >= 2; i--) if (obs[i][15] && !obs[i-1][15]) rise2 = i;
        n_chk++;
        if (rise2 !== 24) $display("FAIL retry_second_pulse got %0d expected 24", rise2);
        else n_pass++;
        n_chk++;
        if (obs[34][11:8] !== 4'd1) $display("FAIL retry_count_before_run got %0d expected 1", obs[34][11:8]);
        else n_pass++;
        n_chk++;
        if (obs[35][13:8] !== 6'b100000) $display("FAIL retry_cleared_in_run got %b expected 100000", obs[35][13:8]);
        else n_pass++;
    endtask

    task automatic test_hard_fail();
        int pulses, first_fail, sys_low;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        for (int i = 2; i < 82; i++) step(0, 2'b00, 0);
        step(0, 2'b00, 1);
        for (int i = 83; i < 86; i++) step(0, 2'b00, 0);
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL hardfail_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
        pulses = 0; first_fail = -1; sys_low = 0;
        for (int i = 0; i < 82; i++) begin
            if (obs[i][15] && (i == 0 || !obs[i-1][15])) pulses++;
            if (obs[i][12] && first_fail < 0) first_fail = i;
            if (!obs[i][14]) sys_low++;
        end
        n_chk++;
        if (pulses !== 3) $display("FAIL hardfail_pulses got %0d expected 3", pulses);
        else n_pass++;
        n_chk++;
        if (first_fail !== 70) $display("FAIL hardfail_time got %0d expected 70", first_fail);
        else n_pass++;
        n_chk++;
        if (sys_low !== 0) $display("FAIL hardfail_sys_rst got %0d low cycles expected 0", sys_low);
        else n_pass++;
        n_chk++;
        if ({obs[81][12], obs[82][12]} !== 2'b10) $display("FAIL hardfail_exit got %b expected 10", {obs[81][12], obs[82][12]});
        else n_pass++;
    endtask

    task automatic test_run_loss(input bit via_status, input string tag);
        int g, d, hi;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        for (int i = 2; i < 6; i++) step(0, 2'b00, 0);
        g = 0;
        while (!ready_o && g < 40) begin step(1, 2'b00, 0); g++; end
        n_chk++;
        if (ready_o !== 1'b1) $display("FAIL %s_reach_run got %b expected 1", tag, ready_o);
        else n_pass++;
        step(1, 2'b00, 0);
        step(1, 2'b00, 0);
        d = n;
        if (via_status) step(1, 2'b01, 0);
        else step(0, 2'b00, 0);
        for (int i = 0; i < 30; i++) step(1, 2'b00, 0);
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL %s_model[%0d] got %h expected %h", tag, i, obs[i], exp_v[i]);
            else n_pass++;
        end
        n_chk++;
        if (obs[d+1][14] !== 1'b0) $display("FAIL %s_sys_early got %b expected 0", tag, obs[d+1][14]);
        else n_pass++;
        n_chk++;
        if ({obs[d+2][15:13], obs[d+2][7:0]} !== 11'b110_00000001)
            $display("FAIL %s_recovery got %b expected 11000000001", tag, {obs[d+2][15:13], obs[d+2][7:0]});
        else n_pass++;
        hi = 0;
        for (int i = d + 2; i < n; i++) hi += int'(obs[i][15]);
        n_chk++;
        if (hi !== 3) $display("FAIL %s_pulse_len got %0d expected 3", tag, hi);
        else n_pass++;
        n_chk++;
        if ({obs[n-1][13], obs[n-1][7:0]} !== 9'h101) $display("FAIL %s_relock got %h expected 101", tag, {obs[n-1][13], obs[n-1][7:0]});
        else n_pass++;
    endtask

    task automatic test_stable_drop();
        int rdy;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        for (int i = 2; i < 9; i++) step(0, 2'b00, 0);
        step(1, 2'b00, 0);
        step(1, 2'b00, 0);
        for (int i = 11; i < 30; i++) step(0, 2'b00, 0);
        for (int i = 30; i < 60; i++) step(1, 2'b00, 0);
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL stable_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
        n_chk++;
        if ({obs[13][15], obs[13][11:8]} !== 5'b1_0001) $display("FAIL stable_retry got %b expected 10001", {obs[13][15], obs[13][11:8]});
        else n_pass++;
        rdy = 0;
        for (int i = 0; i < 30; i++) rdy += int'(obs[i][13]);
        n_chk++;
        if (rdy !== 0) $display("FAIL stable_ready_glitch got %0d expected 0", rdy);
        else n_pass++;
        n_chk++;
        if (obs[n-1][13:8] !== 6'b100000) $display("FAIL stable_final got %b expected 100000", obs[n-1][13:8]);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int hi;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        for (int i = 2; i < 30; i++) step(0, 2'b00, 0);
        step(0, 2'b00, 1);
        for (int i = 31; i < 41; i++) step(0, 2'b00, 0);
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL midrst_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
        n_chk++;
        if (obs[29][15:8] !== 8'b0100_0001) $display("FAIL midrst_second_wait got %b expected 01000001", obs[29][15:8]);
        else n_pass++;
        n_chk++;
        if (obs[30] !== 16'hC000) $display("FAIL midrst_values got %h expected %h", obs[30], 16'hC000);
        else n_pass++;
        hi = 0;
        for (int i = 30; i < n; i++) hi += int'(obs[i][15]);
        n_chk++;
        if (hi !== 3 || obs[33][15] !== 1'b0) $display("FAIL midrst_pulse got %0d expected 3", hi);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int drops, since;
        n = 0;
        step(0, 2'b00, 1);
        step(0, 2'b00, 1);
        drops = 0;
        since = 99;
        while (drops < 260 && n < NMAX - 40) begin
            if (ready_o && since > 3) begin
                step(0, 2'b00, 0);
                drops++;
                since = 0;
            end else begin
                step(1, 2'b00, 0);
                since++;
            end
        end
        for (int i = 0; i < 5; i++) step(1, 2'b00, 0);
        n_chk++;
        if (drops !== 260) $display("FAIL sat_drops got %0d expected 260", drops);
        else n_pass++;
        n_chk++;
        if (obs[n-1][7:0] !== 8'd255) $display("FAIL sat_loss_cnt got %0d expected 255", obs[n-1][7:0]);
        else n_pass++;
        model();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (obs[i] !== exp_v[i]) $display("FAIL sat_model[%0d] got %h expected %h", i, obs[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic       lv;
        logic [1:0] sv;
        logic       rv;
        int         run, bad;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            step(0, 2'b00, 1);
            step(0, 2'b00, 1);
            lv = 1'b0;
            run = 0;
            while (n < 400) begin
                if (run == 0) begin
                    lv  = ($urandom_range(0, 3) != 0);
                    run = int'($urandom_range(1, 40));
                end
                run--;
                sv = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                rv = ($urandom_range(0, 299) == 0);
                step(lv, sv, rv);
            end
            model();
            for (int i = 0; i < n; i++) begin
                n_chk++;
                if (obs[i] !== exp_v[i]) $display("FAIL random%0d_model[%0d] got %h expected %h", t, i, obs[i], exp_v[i]);
                else n_pass++;
            end
            bad = 0;
            for (int i = 0; i < n; i++) if (obs[i][14] === obs[i][13]) bad++;
            n_chk++;
            if (bad !== 0) $display("FAIL random%0d_sys_vs_ready got %0d violations expected 0", t, bad);
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached with %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_lock();
        test_timeout_retry();
        test_hard_fail();
        test_run_loss(1'b0, "loss");
        test_stable_drop();
        test_run_loss(1'b1, "stop");
        test_mid_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
